// File: rtl/exc_seq_ctrl.sv
// Exception sequencing controller: takes SIIC / illegal-opcode events from
// decode, redirects fetch to the handler, flushes younger instructions, and
// returns through the saved EPC on RTI. A second exception while the handler
// is running parks the block in HALTED until reset.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | normal execution, waiting for SIIC or illegal opcode
//   S_ENTER   | flushing into the handler, redirect on first cycle
//   S_HANDLER | handler running, waiting for RTI (or a nested exception)
//   S_RETURN  | flushing back to EPC, redirect on first cycle
//   S_HALTED  | nested exception seen; absorbing until reset
module exc_seq_ctrl #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(16'h0002),
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_opcode,
  input  logic [PC_W-1:0] id_pc_next,
  input  logic            err_in,
  input  logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [PC_W-1:0] epc,
  output logic            in_handler,
  output logic [1:0]      exc_cause,
  output logic            halt_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_HANDLER,
    S_RETURN,
    S_HALTED
  } state_t;

  localparam logic [4:0] OPC_SIIC = 5'b00010;
  localparam logic [4:0] OPC_RTI  = 5'b00011;
  // Counter holds the number of flush cycles still to come after the current one.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [1:0]      cause_q, cause_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            in_handler_q, in_handler_d;
  logic            halt_q, halt_d;

  logic accept;
  logic is_siic;
  logic is_rti;
  logic is_ill;
  logic is_exc;

  assign accept  = id_valid & ~stall;
  assign is_siic = (id_opcode == OPC_SIIC);
  assign is_rti  = (id_opcode == OPC_RTI);
  assign is_ill  = err_in & ~is_siic & ~is_rti;
  assign is_exc  = is_siic | is_ill;

  // Next-state and next-output computation; outputs hold unless a transition changes them.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    flush_d       = flush_q;
    in_handler_d  = in_handler_q;
    halt_d        = halt_q;

    case (state_q)
      S_IDLE: begin
        if (accept && is_exc) begin
          state_d       = S_ENTER;
          cnt_d         = CNT_LOAD;
          epc_d         = id_pc_next;
          cause_d       = is_siic ? 2'b01 : 2'b10;
          redirect_d    = 1'b1;
          redirect_pc_d = HANDLER_ADDR;
          flush_d       = 1'b1;
          in_handler_d  = 1'b1;
        end
      end
      S_ENTER: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HANDLER;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HANDLER: begin
        if (accept && is_exc) begin
          state_d      = S_HALTED;
          cause_d      = 2'b11;
          halt_d       = 1'b1;
          flush_d      = 1'b1;
          in_handler_d = 1'b0;
        end else if (accept && is_rti) begin
          state_d       = S_RETURN;
          cnt_d         = CNT_LOAD;
          redirect_d    = 1'b1;
          redirect_pc_d = epc_q;
          flush_d       = 1'b1;
        end
      end
      S_RETURN: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_IDLE;
          flush_d      = 1'b0;
          in_handler_d = 1'b0;
          cause_d      = 2'b00;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HALTED: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      epc_q         <= '0;
      cause_q       <= 2'b00;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      in_handler_q  <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      in_handler_q  <= in_handler_d;
      halt_q        <= halt_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;
  assign epc         = epc_q;
  assign in_handler  = in_handler_q;
  assign exc_cause   = cause_q;
  assign halt_req    = halt_q;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Bench for exc_seq_ctrl: a default instance (PC_W=16, FLUSH_CYCLES=2) and a
// wide instance (PC_W=32, FLUSH_CYCLES=1) share stimulus and are compared each
// cycle against a mode/remaining-cycles model of the exception sequence.
module tb_exc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_opcode = 5'd0;
  logic [31:0] pc = 32'd0;
  logic        err_in = 1'b0;
  logic        stall = 1'b0;

  logic        redirect0, flush0, in_handler0, halt0;
  logic [15:0] redirect_pc0, epc0;
  logic [1:0]  cause0;
  logic        redirect1, flush1, in_handler1, halt1;
  logic [31:0] redirect_pc1, epc1;
  logic [1:0]  cause1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  exc_seq_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_pc_next(pc[15:0]), .err_in(err_in), .stall(stall),
    .redirect(redirect0), .redirect_pc(redirect_pc0), .flush(flush0),
    .epc(epc0), .in_handler(in_handler0), .exc_cause(cause0), .halt_req(halt0)
  );

  exc_seq_ctrl #(.PC_W(32), .HANDLER_ADDR(32'hCAFE_0010), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_pc_next(pc), .err_in(err_in), .stall(stall),
    .redirect(redirect1), .redirect_pc(redirect_pc1), .flush(flush1),
    .epc(epc1), .in_handler(in_handler1), .exc_cause(cause1), .halt_req(halt1)
  );

  // Reference model. mode: 0 normal, 1 entering, 2 in handler, 3 returning, 4 halted.
  // left = flush cycles remaining including the current one.
  int          m_mode [2];
  int          m_left [2];
  logic [31:0] m_epc  [2];
  logic [1:0]  m_cause[2];
  logic        m_first[2];
  logic [31:0] m_tgt  [2];
  int          m_fc   [2] = '{2, 1};
  logic [31:0] m_ha   [2] = '{32'h0000_0002, 32'hCAFE_0010};
  logic [31:0] m_mask [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_mode[i] = 0; m_left[i] = 0; m_epc[i] = 0; m_cause[i] = 0;
        m_first[i] = 0; m_tgt[i] = 0;
      end else begin
        bit acc, siic, rti, ill;
        acc  = id_valid && !stall;
        siic = (id_opcode == 5'd2);
        rti  = (id_opcode == 5'd3);
        ill  = err_in && !siic && !rti;
        m_first[i] = 0;
        case (m_mode[i])
          0: if (acc && (siic || ill)) begin
            m_mode[i] = 1; m_left[i] = m_fc[i]; m_epc[i] = pc & m_mask[i];
            m_cause[i] = siic ? 2'd1 : 2'd2; m_first[i] = 1; m_tgt[i] = m_ha[i];
          end
          1, 3: begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
              if (m_mode[i] == 1) m_mode[i] = 2;
              else begin m_mode[i] = 0; m_cause[i] = 0; end
            end
          end
          2: if (acc && (siic || ill)) begin
            m_mode[i] = 4; m_cause[i] = 3;
          end else if (acc && rti) begin
            m_mode[i] = 3; m_left[i] = m_fc[i]; m_first[i] = 1; m_tgt[i] = m_epc[i];
          end
          default: ;
        endcase
      end
    end
  end

  // {redirect, redirect_pc, flush, epc, in_handler, exc_cause, halt_req}
  function automatic logic [69:0] obs(int i);
    if (i == 0)
      return {redirect0, 16'h0, redirect_pc0, flush0, 16'h0, epc0, in_handler0, cause0, halt0};
    return {redirect1, redirect_pc1, flush1, epc1, in_handler1, cause1, halt1};
  endfunction

  function automatic logic [69:0] expv(int i);
    logic fl, ih, hl;
    fl = (m_mode[i] == 1) || (m_mode[i] == 3) || (m_mode[i] == 4);
    ih = (m_mode[i] >= 1) && (m_mode[i] <= 3);
    hl = (m_mode[i] == 4);
    return {m_first[i], m_first[i] ? m_tgt[i] : 32'h0, fl, m_epc[i], ih, m_cause[i], hl};
  endfunction

  task automatic drive(input bit v, input logic [4:0] opc, input bit err,
                       input bit stl, input logic [31:0] p);
    id_valid = v; id_opcode = opc; err_in = err; stall = stl; pc = p;
  endtask

  // Quick reset pulse between clock edges; leaves inputs idle.
  task automatic pulse_reset();
    drive(0, 5'd0, 0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs(i) !== 70'h0) begin
        tests_failed++;
        $display("FAIL reset inst%0d got %h want 0", i, obs(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_siic_rti();
    pulse_reset();
    // First accept on the first edge after reset release.
    drive(1, 5'b00010, 0, 0, 32'h0000_0104);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs(i) !== expv(i)) begin
          tests_failed++;
          $display("FAIL siic_rti inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        end
      end
      if (c == 0) begin
        tests_run++;
        if ({redirect0, redirect_pc0, flush0, epc0, cause0} !== {1'b1, 16'h0002, 1'b1, 16'h0104, 2'b01}) begin
          tests_failed++;
          $display("FAIL siic_entry got %b %h %b %h %b want 1 0002 1 0104 01",
                   redirect0, redirect_pc0, flush0, epc0, cause0);
        end
      end
      if (c == 2) begin
        tests_run++;
        if ({in_handler0, flush0} !== 2'b10) begin
          tests_failed++;
          $display("FAIL in_handler got ih=%b fl=%b want ih=1 fl=0", in_handler0, flush0);
        end
      end
      if (c == 3) begin
        tests_run++;
        if ({redirect0, redirect_pc0, flush0} !== {1'b1, 16'h0104, 1'b1}) begin
          tests_failed++;
          $display("FAIL rti_redirect got %b %h %b want 1 0104 1", redirect0, redirect_pc0, flush0);
        end
      end
      if (c == 5) begin
        tests_run++;
        if ({in_handler0, cause0, flush0, epc0} !== {1'b0, 2'b00, 1'b0, 16'h0104}) begin
          tests_failed++;
          $display("FAIL rti_exit got ih=%b cause=%b fl=%b epc=%h want 0 00 0 0104",
                   in_handler0, cause0, flush0, epc0);
        end
      end
      if (c == 0) drive(0, 5'd0, 0, 0, 32'h0);
      if (c == 2) drive(1, 5'b00011, 0, 0, 32'h0000_0FF0);
      if (c == 3) drive(0, 5'd0, 0, 0, 32'h0);
    end
  endtask

  task automatic test_stall();
    pulse_reset();
    drive(1, 5'b11010, 1, 1, 32'h1234_5678);
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs(i) !== expv(i)) begin
          tests_failed++;
          $display("FAIL stall inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        end
      end
      if (c < 3) begin
        tests_run++;
        if ({redirect0, flush0, cause0} !== 4'b0) begin
          tests_failed++;
          $display("FAIL stall_hold cyc%0d got rd=%b fl=%b cause=%b want 0 0 00", c, redirect0, flush0, cause0);
        end
      end
      if (c == 3) begin
        tests_run++;
        if ({redirect0, cause0, redirect1, epc1} !== {1'b1, 2'b10, 1'b1, 32'h1234_5678}) begin
          tests_failed++;
          $display("FAIL stall_release got rd=%b cause=%b rd1=%b epc1=%h want 1 10 1 12345678",
                   redirect0, cause0, redirect1, epc1);
        end
      end
      if (c == 2) drive(1, 5'b11010, 1, 0, 32'h1234_5678);
      if (c == 3) drive(0, 5'd0, 0, 0, 32'h0);
    end
  endtask

  task automatic test_nested();
    pulse_reset();
    drive(1, 5'b00010, 0, 0, 32'h0000_0200);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs(i) !== expv(i)) begin
          tests_failed++;
          $display("FAIL nested inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        end
      end
      if (c == 3) begin
        tests_run++;
        if ({halt0, cause0, halt1, cause1} !== 6'b111111) begin
          tests_failed++;
          $display("FAIL nested_halt got h0=%b c0=%b h1=%b c1=%b want 1 11 1 11", halt0, cause0, halt1, cause1);
        end
      end
      if (c > 3) begin
        tests_run++;
        if ({redirect0, redirect1, halt0, flush0} !== 4'b0011) begin
          tests_failed++;
          $display("FAIL halted_absorb cyc%0d got rd0=%b rd1=%b h0=%b fl0=%b want 0 0 1 1",
                   c, redirect0, redirect1, halt0, flush0);
        end
      end
      if (c == 0) drive(0, 5'd0, 0, 0, 32'h0);
      if (c == 2) drive(1, 5'b00010, 0, 0, 32'h0000_0300);
      if (c == 3) drive(1, 5'b00011, 0, 0, 32'h0000_0400);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs(i) !== 70'h0) begin
        tests_failed++;
        $display("FAIL nested_reset inst%0d got %h want 0", i, obs(i));
      end
    end
    rst_n = 1'b1;
    drive(0, 5'd0, 0, 0, 32'h0);
  endtask

  task automatic test_rti_idle();
    pulse_reset();
    drive(1, 5'b00011, 1, 0, 32'h0000_0500);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs(i) !== 70'h0) begin
          tests_failed++;
          $display("FAIL rti_idle inst%0d cyc%0d got %h want 0", i, c, obs(i));
        end
      end
    end
    // Wide variant: one flush cycle, full 32-bit EPC.
    drive(1, 5'b00010, 0, 0, 32'hF00D_BEEE);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({flush1, epc1, in_handler1} !== {c == 0, 32'hF00D_BEEE, 1'b1}) begin
        tests_failed++;
        $display("FAIL wide_enter cyc%0d got fl=%b epc=%h ih=%b want fl=%0d epc=f00dbeee ih=1",
                 c, flush1, epc1, in_handler1, c == 0);
      end
      drive(0, 5'd0, 0, 0, 32'h0);
    end
  endtask

  task automatic test_reset_mid_enter();
    pulse_reset();
    drive(1, 5'b00010, 0, 0, 32'h0000_0104);
    @(posedge clk); #1;
    drive(0, 5'd0, 0, 0, 32'h0);
    @(posedge clk); #1;
    tests_run++;
    if ({flush0, in_handler0, cause0} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL enter2 got fl=%b ih=%b cause=%b want 1 1 01", flush0, in_handler0, cause0);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs(i) !== 70'h0) begin
        tests_failed++;
        $display("FAIL async_reset inst%0d got %h want 0", i, obs(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 600; c++) begin
      logic [4:0] opc;
      int r;
      r = $urandom_range(0, 9);
      opc = (r < 3) ? 5'b00010 : (r < 6) ? 5'b00011 : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, opc, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        tests_run++;
        if (obs(i) !== expv(i)) begin
          tests_failed++;
          $display("FAIL random inst%0d cyc%0d got %h want %h", i, c, obs(i), expv(i));
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_siic_rti();
    test_stall();
    test_nested();
    test_rti_idle();
    test_reset_mid_enter();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exc_seq_ctrl.md
EXC_SEQ_CTRL -- requirements
Module: exc_seq_ctrl

Interface
REQ-001 SHALL provide parameter PC_W, default 16, width of all PC buses; legal range 8..32.
REQ-002 SHALL provide parameter HANDLER_ADDR, default 16'h0002 (zero-extended to PC_W), exception handler entry PC.
REQ-003 SHALL provide parameter FLUSH_CYCLES, default 2, number of cycles flush is held per redirect; legal range 1..15.
REQ-004 Ports: clk  in  1  sole clock, rising edge; all state updates on this edge.
REQ-005 Ports: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: id_valid  in  1  decode-stage instruction valid.
REQ-007 Ports: id_opcode  in  5  decode-stage opcode.
REQ-008 Ports: id_pc_next  in  PC_W  PC+2 of the decode-stage instruction.
REQ-009 Ports: err_in  in  1  illegal-opcode flag from the decode control unit.
REQ-010 Ports: stall  in  1  decode stage held; blocks event acceptance.
REQ-011 Ports: redirect  out  1  one-cycle PC load pulse.
REQ-012 Ports: redirect_pc  out  PC_W  target PC, valid when redirect=1, else 0.
REQ-013 Ports: flush  out  1  squash younger pipeline instructions.
REQ-014 Ports: epc  out  PC_W  saved exception return PC.
REQ-015 Ports: in_handler  out  1  handler mode active.
REQ-016 Ports: exc_cause  out  2  00 none, 01 siic, 10 illegal opcode, 11 nested.
REQ-017 Ports: halt_req  out  1  sticky request to halt the processor.

Function
REQ-018 Accept = id_valid & ~stall; no event is acted on without accept.
REQ-019 States: IDLE, ENTER, HANDLER, RETURN, HALTED.
REQ-020 Event decode: SIIC = opcode 00010; RTI = opcode 00011; ILL = err_in & opcode not in {00010,00011}.
REQ-021 IDLE + accept + SIIC -> ENTER; epc <= id_pc_next; exc_cause <= 01.
REQ-022 IDLE + accept + ILL -> ENTER; epc <= id_pc_next; exc_cause <= 10.
REQ-023 IDLE + RTI is a NOP: no state change, no outputs change.
REQ-024 ENTER lasts exactly FLUSH_CYCLES cycles, counted by a 4-bit down-counter; flush=1 for every ENTER cycle.
REQ-025 redirect=1 with redirect_pc=HANDLER_ADDR only in the first ENTER cycle, i.e. 1 cycle after the accepting edge.
REQ-026 After the last ENTER cycle -> HANDLER; in_handler=1 throughout ENTER, HANDLER and RETURN.
REQ-027 HANDLER + accept + RTI -> RETURN; RETURN lasts FLUSH_CYCLES cycles with flush=1.
REQ-028 redirect=1 with redirect_pc=epc only in the first RETURN cycle.
REQ-029 After the last RETURN cycle -> IDLE; in_handler=0, exc_cause <= 00; epc is retained.
REQ-030 HANDLER + accept + (SIIC or ILL) -> HALTED; exc_cause <= 11; halt_req=1 from the next cycle.
REQ-031 HALTED is absorbing until reset: flush=1, redirect=0, all inputs ignored.
REQ-032 ENTER and RETURN ignore all inputs; the counter decrements regardless of stall.
REQ-033 If SIIC/ILL and RTI are offered simultaneously, opcode priority is SIIC > ILL; only one event is accepted per cycle.
REQ-034 The epc and redirect_pc paths are PC_W wide; no arithmetic is done on PCs, so wrap-around cannot occur inside the block.
REQ-035 All outputs are registered or derived only from state; no combinational input-to-output path.

Reset
REQ-036 rst_n=0 asynchronously forces IDLE, counter=0, epc=0, exc_cause=00, and all 1-bit outputs to 0, including mid-ENTER, mid-RETURN and in HALTED.
REQ-037 The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 SIIC at id_pc_next=16'h0104, defaults -> next cycle redirect=1, redirect_pc=16'h0002, flush=1 for 2 cycles, epc=16'h0104, exc_cause=01, then in_handler=1.
REQ-039 In HANDLER, RTI accepted -> next cycle redirect=1, redirect_pc=16'h0104, flush 2 cycles, then in_handler=0, exc_cause=00.
REQ-040 err_in=1, opcode 11010 held with stall=1 for 3 cycles, then stall=0 -> no action while stalled; ENTER begins 1 cycle after stall drops; exc_cause=10.
REQ-041 SIIC while in HANDLER -> exc_cause=11, halt_req=1 sticky; a later RTI gives no redirect; rst_n pulse clears everything.
REQ-042 RTI in IDLE -> no redirect, no flush, outputs unchanged; FLUSH_CYCLES=1, PC_W=32 variant -> single flush cycle, full 32-bit epc captured.
REQ-043 rst_n asserted during the second ENTER cycle -> all outputs 0 immediately, without waiting for a clock edge.
